vga_fb_reader: RTL and testbench

Display-side reader for the camera frame buffer. It generates 640x480@60 VGA timing from a 25 MHz pixel clock and fetches one 12-bit RGB444 pixel per active cycle from frame-buffer RAM. It presents the pixels on the VGA pins with hsync, vsync and de aligned to them. It sits between the frame-buffer RAM read port and the VGA connector, and selects one of two camera banks per frame.

---
 rtl/vga_fb_reader_pkg.sv | 20 ++
 rtl/vga_fb_reader_timing.sv | 64 ++++++
 rtl/vga_fb_reader.sv | 116 +++++++++++
 tb/tb_vga_fb_reader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_reader_pkg.sv
// Shared constants for the camera frame-buffer display path: default VGA 640x480 timing,
// bank geometry and pixel format (RGB444 is shared with the capture side).
package vga_fb_reader_pkg;
  localparam int H_ACT_DEF  = 640;
  localparam int H_FP_DEF   = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF   = 48;
  localparam int V_ACT_DEF  = 480;
  localparam int V_FP_DEF   = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF   = 33;

  localparam int BANK_SIZE_DEF = H_ACT_DEF * V_ACT_DEF;
  localparam int ADDR_W        = 20;
  localparam int PIX_W         = 12;
  localparam int CNT_W         = 10;

  typedef logic [PIX_W-1:0]  rgb444_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
endpackage

// File: rtl/vga_fb_reader_timing.sv
// VGA raster timing: pixel/line counters with stage-0 decode of active area, syncs and
// frame boundaries. Kept standalone so an overlay block can reuse it.
module vga_fb_reader_timing
  import vga_fb_reader_pkg::*;
#(
  parameter int   H_ACT    = H_ACT_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACT    = V_ACT_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic active_o,
  output logic hs_o,
  output logic vs_o,
  output logic sof_o,
  output logic eof_o
);
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACTC = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACTC = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACT + V_FP + V_SYNC - 1);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Stage 0: decode straight from the counters
  assign active_o = (h_cnt_q < H_ACTC) && (v_cnt_q < V_ACTC);
  assign hs_o     = ((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END)) ? SYNC_POL : ~SYNC_POL;
  assign vs_o     = ((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END)) ? SYNC_POL : ~SYNC_POL;
  assign sof_o    = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign eof_o    = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
endmodule

// File: rtl/vga_fb_reader.sv
// Frame-buffer display reader: linear RAM fetch during the active area, with syncs, de and
// frame_start delayed to line up with the returned pixel on the VGA pins.
module vga_fb_reader
  import vga_fb_reader_pkg::*;
#(
  parameter int   H_ACT     = H_ACT_DEF,
  parameter int   H_FP      = H_FP_DEF,
  parameter int   H_SYNC    = H_SYNC_DEF,
  parameter int   H_BP      = H_BP_DEF,
  parameter int   V_ACT     = V_ACT_DEF,
  parameter int   V_FP      = V_FP_DEF,
  parameter int   V_SYNC    = V_SYNC_DEF,
  parameter int   V_BP      = V_BP_DEF,
  parameter int   BANK_SIZE = BANK_SIZE_DEF,
  parameter int   RD_LAT    = 1,
  parameter logic SYNC_POL  = 1'b0
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              bank_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  input  logic [PIX_W-1:0]  ram_data,
  output logic [PIX_W-1:0]  vga_rgb,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic              frame_start
);
  localparam int       PD        = RD_LAT + 1;
  localparam fb_addr_t BANK_BASE = ADDR_W'(BANK_SIZE);

  logic active, hs0, vs0, sof, eof;

  vga_fb_reader_timing #(
    .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .clk_i(pclk), .rst_i(rst),
    .active_o(active), .hs_o(hs0), .vs_o(vs0), .sof_o(sof), .eof_o(eof)
  );

  logic     bank_q;
  fb_addr_t addr_q, addr_d;
  logic     en_q, en_d;

  // Bank only changes on the last cycle of a frame so a switch never tears the picture
  always_ff @(posedge pclk) begin
    if (rst)      bank_q <= bank_sel;
    else if (eof) bank_q <= bank_sel;
  end

  always_comb begin
    addr_d = addr_q;
    en_d   = active;
    if (sof)         addr_d = bank_q ? BANK_BASE : '0;
    else if (active) addr_d = addr_q + ADDR_W'(1);
  end

  // Stage 1: registered RAM request
  always_ff @(posedge pclk) begin
    if (rst) begin
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      addr_q <= addr_d;
      en_q   <= en_d;
    end
  end

  assign ram_addr = addr_q;
  assign ram_en   = en_q;

  logic [PD-1:0] de_sr_q, hs_sr_q, vs_sr_q, fs_sr_q;
  rgb444_t       rgb_q;
  logic          de_q, hs_q, vs_q, fs_q;

  // Stages 1..1+RD_LAT: control flags track the RAM request until its data returns
  always_ff @(posedge pclk) begin
    if (rst) begin
      de_sr_q <= '0;
      fs_sr_q <= '0;
      hs_sr_q <= {PD{~SYNC_POL}};
      vs_sr_q <= {PD{~SYNC_POL}};
    end else begin
      de_sr_q <= {de_sr_q[PD-2:0], active};
      fs_sr_q <= {fs_sr_q[PD-2:0], sof};
      hs_sr_q <= {hs_sr_q[PD-2:0], hs0};
      vs_sr_q <= {vs_sr_q[PD-2:0], vs0};
    end
  end

  // Stage 2+RD_LAT: output registers; blanking is forced black regardless of RAM contents
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q <= '0;
      de_q  <= 1'b0;
      fs_q  <= 1'b0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      rgb_q <= de_sr_q[PD-1] ? ram_data : '0;
      de_q  <= de_sr_q[PD-1];
      fs_q  <= fs_sr_q[PD-1];
      hs_q  <= hs_sr_q[PD-1];
      vs_q  <= vs_sr_q[PD-1];
    end
  end

  assign vga_rgb     = rgb_q;
  assign vga_de      = de_q;
  assign frame_start = fs_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
endmodule

// File: tb/tb_vga_fb_reader.sv
// Bench for vga_fb_reader on a shrunken raster; RD_LAT=1 and RD_LAT=2 builds run side by side.
module tb_vga_fb_reader;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int BS = HA * VA;

  logic clk = 1'b0;
  logic rst, bank_sel;
  logic [19:0] addr1, addr2;
  logic        en1, en2;
  logic [11:0] d1, d2a, d2, rgb1, rgb2;
  logic        hs1, vs1, de1, fs1, hs2, vs2, de2, fs2;

  always #5 clk = ~clk;

  vga_fb_reader #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BANK_SIZE(BS), .RD_LAT(1), .SYNC_POL(1'b0)
  ) u_dut1 (
    .pclk(clk), .rst(rst), .bank_sel(bank_sel), .ram_addr(addr1), .ram_en(en1),
    .ram_data(d1), .vga_rgb(rgb1), .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1),
    .frame_start(fs1)
  );

  vga_fb_reader #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .BANK_SIZE(BS), .RD_LAT(2), .SYNC_POL(1'b0)
  ) u_dut2 (
    .pclk(clk), .rst(rst), .bank_sel(bank_sel), .ram_addr(addr2), .ram_en(en2),
    .ram_data(d2), .vga_rgb(rgb2), .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2),
    .frame_start(fs2)
  );

  // RAM models: data = addr[11:0]; junk whenever the read is not enabled
  always @(posedge clk) begin
    d1  <= en1 ? addr1[11:0] : 12'($urandom);
    d2a <= en2 ? addr2[11:0] : 12'($urandom);
    d2  <= d2a;
  end

  typedef struct packed {
    logic        en;
    logic [19:0] addr;
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
    logic        fs;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int          tests = 0;
  int          fails = 0;
  int          mh, mv;
  logic        mbank;
  logic [19:0] mlast;
  int          en_cnt, de_cnt, hs_cnt, vs_cnt;

  function automatic exp_t reset_t();
    exp_t r;
    r    = '0;
    r.hs = 1'b1;
    r.vs = 1'b1;
    return r;
  endfunction

  function automatic exp_t model_t();
    exp_t t;
    logic act;
    act    = (mh < HA) && (mv < VA);
    t.en   = act;
    t.de   = act;
    t.addr = act ? 20'((mbank ? BS : 0) + mv * HA + mh) : mlast;
    t.rgb  = act ? t.addr[11:0] : 12'h000;
    t.hs   = !((mh >= HA + HF) && (mh < HA + HF + HS));
    t.vs   = !((mv >= VA + VF) && (mv < VA + VF + VS));
    t.fs   = (mh == 0) && (mv == 0);
    return t;
  endfunction

  task automatic model_reset();
    mh = 0;
    mv = 0;
    mbank = bank_sel;
    mlast = '0;
    q1.delete();
    q2.delete();
    repeat (3) q1.push_back(reset_t());
    repeat (4) q2.push_back(reset_t());
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string tag, input exp_t eo, input exp_t er,
                           input logic [11:0] rgb, input logic de, input logic hs,
                           input logic vs, input logic fs, input logic en,
                           input logic [19:0] addr);
    chk({tag, ".rgb"}, 32'(rgb), 32'(eo.rgb));
    chk({tag, ".de"}, 32'(de), 32'(eo.de));
    chk({tag, ".hs"}, 32'(hs), 32'(eo.hs));
    chk({tag, ".vs"}, 32'(vs), 32'(eo.vs));
    chk({tag, ".frame_start"}, 32'(fs), 32'(eo.fs));
    chk({tag, ".ram_en"}, 32'(en), 32'(er.en));
    chk({tag, ".ram_addr"}, 32'(addr), 32'(er.addr));
  endtask

  // Called mid-cycle: compare DUT against scoreboard, then advance the model by one clock
  task automatic step();
    exp_t cur;
    check_dut("lat1", q1[0], q1[$], rgb1, de1, hs1, vs1, fs1, en1, addr1);
    check_dut("lat2", q2[0], q2[$], rgb2, de2, hs2, vs2, fs2, en2, addr2);
    en_cnt += int'(en1);
    de_cnt += int'(de2);
    hs_cnt += int'(!hs1);
    vs_cnt += int'(!vs2);
    if (rst) begin
      model_reset();
    end else begin
      cur = model_t();
      if (cur.en) mlast = cur.addr;
      void'(q1.pop_front());
      q1.push_back(cur);
      void'(q2.pop_front());
      q2.push_back(cur);
      if (mh == HT - 1) begin
        if (mv == VT - 1) mbank = bank_sel;
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh++;
      end
    end
    @(negedge clk);
  endtask

  task automatic seek(input int h, input int v);
    int n;
    n = 0;
    while (!((mh == h) && (mv == v)) && (n < 2 * HT * VT)) begin
      step();
      n++;
    end
    chk("seek_reached", 32'((mh == h) && (mv == v)), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    bank_sel = 1'b0;
    model_reset();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    repeat (HT * VT + 10) step();
    en_cnt = 0;
    de_cnt = 0;
    vs_cnt = 0;
    repeat (HT * VT) step();
    chk("frame_ram_en_count", 32'(en_cnt), 32'(BS));
    chk("frame_de_count", 32'(de_cnt), 32'(BS));
    chk("frame_vs_low_count", 32'(vs_cnt), 32'(VS * HT));
    hs_cnt = 0;
    repeat (HT) step();
    chk("line_hs_low_count", 32'(hs_cnt), 32'(HS));

    seek(0, 3);
    bank_sel = 1'b1;
    repeat (2 * HT * VT) step();

    seek(10, 2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    repeat (HT * VT + 20) step();

    bank_sel = 1'b0;
    repeat (2 * HT * VT) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
